// File: rtl/seq_stage_controller.sv
// Multicycle stage sequencer for the SEQ Y86-64 datapath: one stage per clock, status tracking, cycle/instr counters.
// Optional build macro SEQ_MEM_TIMEOUT_EN adds a MEMORY-stage timeout that halts with ADR.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for start
// FETCH     | instruction fetch; icode/fault flags sampled on exit
// DECODE    | register read
// EXECUTE   | ALU; picks MEMORY, WRITEBACK or PCUPDATE next
// MEMORY    | data access; held until mem_ready
// WRITEBACK | register-file write strobe
// PCUPDATE  | PC update; instruction retires
// HALT      | stopped on HLT/ADR/INS until reset
module seq_stage_controller #(
    parameter int COUNT_WIDTH = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [3:0]             icode,
    input  logic                   instr_valid,
    input  logic                   imem_error,
    input  logic                   mem_ready,
    input  logic                   dmem_error,
    output logic                   fetch_en,
    output logic                   decode_en,
    output logic                   execute_en,
    output logic                   memory_en,
    output logic                   writeback_en,
    output logic                   pc_update_en,
    output logic [2:0]             stat,
    output logic                   busy,
    output logic                   halted,
    output logic [COUNT_WIDTH-1:0] cycle_count,
    output logic [COUNT_WIDTH-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEMORY,
        S_WRITEBACK,
        S_PCUPDATE,
        S_HALT
    } state_t;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

    if (MEM_TIMEOUT < 1) begin : g_bad_timeout
        $error("MEM_TIMEOUT must be at least 1");
    end

    state_t     state;
    state_t     state_nxt;
    logic [2:0] stat_nxt;
    logic [3:0] icode_q;

`ifdef SEQ_MEM_TIMEOUT_EN
    localparam int TMO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(MEM_TIMEOUT - 1);
    logic [TMO_W-1:0] tmo_cnt;
`endif

    function automatic logic uses_memory(input logic [3:0] ic);
        case (ic)
            4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: uses_memory = 1'b1;
            default:                            uses_memory = 1'b0;
        endcase
    endfunction

    always_comb begin
        state_nxt = state;
        stat_nxt  = stat;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (imem_error) begin
                    stat_nxt  = STAT_ADR;
                    state_nxt = S_HALT;
                end else if (!instr_valid) begin
                    stat_nxt  = STAT_INS;
                    state_nxt = S_HALT;
                end else if (icode == 4'h0) begin
                    stat_nxt  = STAT_HLT;
                    state_nxt = S_HALT;
                end else begin
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: state_nxt = S_EXECUTE;
            S_EXECUTE: begin
                if (uses_memory(icode_q))
                    state_nxt = S_MEMORY;
                else if (icode_q == 4'h1 || icode_q == 4'h7)
                    state_nxt = S_PCUPDATE;
                else
                    state_nxt = S_WRITEBACK;
            end
            S_MEMORY: begin
                if (mem_ready) begin
                    if (dmem_error) begin
                        stat_nxt  = STAT_ADR;
                        state_nxt = S_HALT;
                    end else if (icode_q == 4'h4) begin
                        state_nxt = S_PCUPDATE;
                    end else begin
                        state_nxt = S_WRITEBACK;
                    end
                end
`ifdef SEQ_MEM_TIMEOUT_EN
                else if (tmo_cnt == '0) begin
                    stat_nxt  = STAT_ADR;
                    state_nxt = S_HALT;
                end
`endif
            end
            S_WRITEBACK: state_nxt = S_PCUPDATE;
            S_PCUPDATE:  state_nxt = S_FETCH;
            S_HALT:      state_nxt = S_HALT;
            default:     state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            stat         <= STAT_AOK;
            icode_q      <= 4'h0;
            fetch_en     <= 1'b0;
            decode_en    <= 1'b0;
            execute_en   <= 1'b0;
            memory_en    <= 1'b0;
            writeback_en <= 1'b0;
            pc_update_en <= 1'b0;
            busy         <= 1'b0;
            halted       <= 1'b0;
            cycle_count  <= '0;
            instr_count  <= '0;
`ifdef SEQ_MEM_TIMEOUT_EN
            tmo_cnt      <= TMO_LOAD;
`endif
        end else begin
            state        <= state_nxt;
            stat         <= stat_nxt;
            fetch_en     <= (state_nxt == S_FETCH);
            decode_en    <= (state_nxt == S_DECODE);
            execute_en   <= (state_nxt == S_EXECUTE);
            memory_en    <= (state_nxt == S_MEMORY);
            writeback_en <= (state_nxt == S_WRITEBACK);
            pc_update_en <= (state_nxt == S_PCUPDATE);
            busy         <= (state_nxt != S_IDLE) && (state_nxt != S_HALT);
            halted       <= (state_nxt == S_HALT);
            if (state == S_FETCH)
                icode_q <= icode;
            if (busy && cycle_count != COUNT_MAX)
                cycle_count <= cycle_count + 1'b1;
            if (state == S_PCUPDATE && instr_count != COUNT_MAX)
                instr_count <= instr_count + 1'b1;
`ifdef SEQ_MEM_TIMEOUT_EN
            // Down-counter reloads whenever outside MEMORY, so each entry starts a fresh window.
            if (state != S_MEMORY)
                tmo_cnt <= TMO_LOAD;
            else if (tmo_cnt != '0)
                tmo_cnt <= tmo_cnt - 1'b1;
`endif
        end
    end

endmodule
